alpaca_bfly_sched: RTL and testbench
====================================

# alpaca_bfly_sched

Sequencer for one shared radix-2 butterfly unit, which works on `cx_t` samples, `wk_t` twiddles and `arith_t` results. It runs an in-place decimation-in-time FFT of `FFT_LEN` points over `LOGN` stages. On each cycle it issues one butterfly's read-address pair, twiddle index and stage number. It also produces the matching write-back addresses and per-stage scale flag, aligned to the butterfly pipeline output. It sits between the sample RAM / twiddle ROM and the butterfly datapath, and a `start`/`done` handshake hands the block to the frame controller.

## Interface
- `FFT_LEN`, default 64: transform length. Must be a power of two, ≥ 4. `LOGN = $clog2(FFT_LEN)`.
- `RD_LAT`, default 1: sample RAM and twiddle ROM read latency in cycles. Must be ≥ 1.
- `BFLY_LAT`, default 2: butterfly latency in cycles, from operands valid to result valid. Must be ≥ 1.
- `SCALE_SCHED`, default '1: `LOGN`-bit mask. When bit s is 1, stage s results are shifted right by 1 on write-back.
- `clk`, in, 1: clock. All state updates on its rising edge.
- `rst`, in, 1: asynchronous active-high reset.
- `start`, in, 1: request one transform. Sampled only in IDLE.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse when the last write-back has been issued.
- `rd_en`, out, 1: read strobe to the sample RAM and twiddle ROM.
- `rd_addr_a`, out, `LOGN`: upper butterfly operand address.
- `rd_addr_b`, out, `LOGN`: lower butterfly operand address.
- `tw_idx`, out, `LOGN-1`: twiddle ROM index k.
- `stage`, out, `$clog2(LOGN)`: current stage, valid while `rd_en` is high.
- `wr_en`, out, 1: write-back strobe. Equals `rd_en` delayed by `PIPE_LAT = RD_LAT + BFLY_LAT` cycles.
- `wr_addr_a`, out, `LOGN`: `rd_addr_a` delayed by `PIPE_LAT` cycles.
- `wr_addr_b`, out, `LOGN`: `rd_addr_b` delayed by `PIPE_LAT` cycles.
- `wr_scale`, out, 1: `SCALE_SCHED[stage]` delayed by `PIPE_LAT` cycles.

## Operation
- The state machine has four states: IDLE, RUN, DRAIN, DONE.
- IDLE: when `start` is high, go to RUN. At the same time, clear the stage counter s and the butterfly counter j.
- RUN: `rd_en` is high every cycle and j increments. When j = `FFT_LEN`/2 − 1, clear j and go to DRAIN.
- DRAIN: lasts exactly `PIPE_LAT` cycles with `rd_en` low, so the next stage cannot read a location before its previous-stage write has landed.
  - At the end of DRAIN, if s = `LOGN`−1, go to DONE.
  - Otherwise increment s and go to RUN.
- DONE: one cycle with `done` high, then go to IDLE.
- Address generation is combinational from the registered s and j.
  - span = 2^s, pos = j & (span−1), grp = j >> s.
  - `rd_addr_a` = grp·2·span + pos.
  - `rd_addr_b` = `rd_addr_a` + span.
  - `tw_idx` = pos << (`LOGN`−1−s).
- Write path: a `PIPE_LAT`-deep shift register carries {`rd_en`, `rd_addr_a`, `rd_addr_b`, scale bit}.
- `start` while busy is ignored and does not queue a request.
- `rd_addr_*`, `tw_idx` and `stage` are don't-care when `rd_en` is low. The bench checks them only while `rd_en` is high.

## Timing
- Reset values: state IDLE, s = 0, j = 0, shift register cleared, and every output 0.
- Reset asserted mid-transform: all outputs go to 0 asynchronously, with no spurious `wr_en` after release.
- Release behaviour: the block sits in IDLE until a fresh `start` arrives.
- With `start` high at edge e0, the first `rd_en` is high in the cycle after e0.
- Stage timing: each stage takes `FFT_LEN`/2 RUN cycles plus `PIPE_LAT` DRAIN cycles.
- `done` is high in cycle `LOGN`·(`FFT_LEN`/2 + `PIPE_LAT`) + 1 after e0.
- `busy` is high from cycle 1 through the `done` cycle inclusive.
- The last `wr_en` of the transform occurs in the cycle immediately before `done`.
- Back-to-back transforms: `start` held high through `done` begins the next transform the cycle after the block returns to IDLE. Minimum gap is one IDLE cycle.
- Within a stage, the {a, b} pairs are disjoint and together cover every address exactly once.

## Test plan
- Reset and idle: `FFT_LEN`=16, `RD_LAT`=1, `BFLY_LAT`=2. With `rst` pulsed and no `start`, all outputs stay 0 for 50 cycles.
- Full sequence: `start` at e0.
  - Stage 0, first two issues: (0, 1, k=0), (2, 3, k=0).
  - Stage 1, j=1: (1, 3, k=4).
  - Stage 3, j=7: (7, 15, k=7).
  - `done` pulses at cycle 45.
- Write alignment: every `wr_en`/`wr_addr` pair equals the `rd` values from 3 cycles earlier. Across the whole transform, exactly 32 `wr_en` cycles with no overlap between stages.
- Scale schedule: `SCALE_SCHED`=4'b0101. `wr_scale` is 1 only on writes belonging to stages 0 and 2.
- Start while busy: a `start` pulse in cycle 10 has no effect. The `done` count is 1 and timing is unchanged.
- Reset mid-run: `rst` asserted at cycle 20 forces all outputs to 0 immediately.
  - No `wr_en` occurs after release.
  - A new `start` then completes normally with `done` at 45 cycles after it.

Source files
------------

// File: rtl/alpaca_bfly_sched_if.sv
// Handshake and address bus between the butterfly sequencer and its
// sample RAM / twiddle ROM / datapath neighbours.
interface alpaca_bfly_sched_if #(
  parameter int FFT_LEN = 64
);
  localparam int LOGN = $clog2(FFT_LEN);
  localparam int SW   = $clog2(LOGN);

  logic            start;
  logic            busy;
  logic            done;
  logic            rd_en;
  logic [LOGN-1:0] rd_addr_a;
  logic [LOGN-1:0] rd_addr_b;
  logic [LOGN-2:0] tw_idx;
  logic [SW-1:0]   stage;
  logic            wr_en;
  logic [LOGN-1:0] wr_addr_a;
  logic [LOGN-1:0] wr_addr_b;
  logic            wr_scale;

  modport master (
    input  start,
    output busy, done,
    output rd_en, rd_addr_a, rd_addr_b, tw_idx, stage,
    output wr_en, wr_addr_a, wr_addr_b, wr_scale
  );

  modport slave (
    output start,
    input  busy, done,
    input  rd_en, rd_addr_a, rd_addr_b, tw_idx, stage,
    input  wr_en, wr_addr_a, wr_addr_b, wr_scale
  );
endinterface

// File: rtl/alpaca_bfly_sched.sv
// In-place radix-2 DIT FFT sequencer: issues one butterfly per cycle and
// replays its addresses and scale flag aligned to the butterfly output.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; s and j cleared on acceptance
//   RUN   | one butterfly read issued per cycle, j counts 0..FFT_LEN/2-1
//   DRAIN | PIPE_LAT cycles without reads so the stage's writes land
//   DONE  | single-cycle done pulse, back to IDLE
module alpaca_bfly_sched #(
  parameter int FFT_LEN  = 64,
  parameter int RD_LAT   = 1,
  parameter int BFLY_LAT = 2,
  parameter logic [$clog2(FFT_LEN)-1:0] SCALE_SCHED = '1
) (
  input logic clk,
  input logic rst,
  alpaca_bfly_sched_if.master bus
);

  localparam int LOGN     = $clog2(FFT_LEN);
  localparam int SW       = $clog2(LOGN);
  localparam int JW       = LOGN - 1;
  localparam int PIPE_LAT = RD_LAT + BFLY_LAT;
  localparam int CW       = $clog2(PIPE_LAT + 1);

  localparam logic [JW-1:0] J_LAST   = JW'(FFT_LEN / 2 - 1);
  localparam logic [SW-1:0] S_LAST   = SW'(LOGN - 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(PIPE_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic            en;
    logic [LOGN-1:0] a;
    logic [LOGN-1:0] b;
    logic            sc;
  } wb_t;

  state_t          state;
  logic [SW-1:0]   s;
  logic [JW-1:0]   j;
  logic [CW-1:0]   drain_cnt;
  logic            rd_en_q;
  logic            busy_q;
  logic            done_q;

  logic [LOGN-1:0] jx;
  logic [LOGN-1:0] span;
  logic [LOGN-1:0] pos;
  logic [LOGN-1:0] grp;
  logic [LOGN-1:0] addr_a;
  logic [LOGN-1:0] addr_b;
  logic [JW-1:0]   tw_c;
  logic            scale_c;

  wb_t             pipe [PIPE_LAT];
  wb_t             issue;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      s         <= '0;
      j         <= '0;
      drain_cnt <= '0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= RUN;
            s       <= '0;
            j       <= '0;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (j == J_LAST) begin
            j         <= '0;
            drain_cnt <= CNT_INIT;
            rd_en_q   <= 1'b0;
            state     <= DRAIN;
          end else begin
            j <= j + JW'(1);
          end
        end
        DRAIN: begin
          // Down-counter terminal count ends the drain window.
          if (drain_cnt == '0) begin
            if (s == S_LAST) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              s       <= s + SW'(1);
              rd_en_q <= 1'b1;
              state   <= RUN;
            end
          end else begin
            drain_cnt <= drain_cnt - CW'(1);
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state   <= IDLE;
          rd_en_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Butterfly j of stage s: group grp, offset pos inside a span-wide half.
  always_comb begin
    jx      = {1'b0, j};
    span    = LOGN'(1) << s;
    pos     = jx & (span - LOGN'(1));
    grp     = jx >> s;
    addr_a  = ((grp << s) << 1) | pos;
    addr_b  = addr_a | span;
    tw_c    = JW'(pos << (S_LAST - s));
    scale_c = SCALE_SCHED[s];
  end

  always_comb begin
    issue    = '0;
    issue.en = rd_en_q;
    if (rd_en_q) begin
      issue.a  = addr_a;
      issue.b  = addr_b;
      issue.sc = scale_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= issue;
      for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr_a = issue.a;
  assign bus.rd_addr_b = issue.b;
  assign bus.tw_idx    = rd_en_q ? tw_c : '0;
  assign bus.stage     = rd_en_q ? s : '0;
  assign bus.wr_en     = pipe[PIPE_LAT-1].en;
  assign bus.wr_addr_a = pipe[PIPE_LAT-1].a;
  assign bus.wr_addr_b = pipe[PIPE_LAT-1].b;
  assign bus.wr_scale  = pipe[PIPE_LAT-1].sc;

endmodule

// File: tb/tb_alpaca_bfly_sched.sv
// Randomized self-checking bench for alpaca_bfly_sched against a
// block/pair enumeration model of the in-place DIT schedule.
module tb_alpaca_bfly_sched;

  localparam int N     = 16;
  localparam int LOGN  = 4;
  localparam int HALF  = N / 2;
  localparam int PIPE  = 3;
  localparam int DC    = LOGN * (HALF + PIPE) + 1;
  localparam logic [3:0] SCALE = 4'b0101;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  alpaca_bfly_sched_if #(.FFT_LEN(N)) bus_if ();

  alpaca_bfly_sched #(
    .FFT_LEN    (N),
    .RD_LAT     (1),
    .BFLY_LAT   (2),
    .SCALE_SCHED(SCALE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  logic [25:0] all_outs;
  assign all_outs = {bus_if.busy, bus_if.done, bus_if.rd_en, bus_if.rd_addr_a,
                     bus_if.rd_addr_b, bus_if.tw_idx, bus_if.stage, bus_if.wr_en,
                     bus_if.wr_addr_a, bus_if.wr_addr_b, bus_if.wr_scale};

  // Expected per-cycle schedule, indexed by cycle after the start edge.
  bit m_rd [64];
  int m_a  [64];
  int m_b  [64];
  int m_k  [64];
  int m_st [64];
  bit m_wr [64];
  int m_wa [64];
  int m_wb [64];
  bit m_ws [64];
  int m_wst[64];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic void build_model();
    int cyc;
    int span;
    for (int c = 0; c < 64; c++) begin
      m_rd[c] = 0; m_a[c] = 0; m_b[c] = 0; m_k[c] = 0; m_st[c] = 0;
      m_wr[c] = 0; m_wa[c] = 0; m_wb[c] = 0; m_ws[c] = 0; m_wst[c] = 0;
    end
    for (int st = 0; st < LOGN; st++) begin
      span = 1 << st;
      cyc  = 1 + st * (HALF + PIPE);
      for (int base = 0; base < N; base += 2 * span) begin
        for (int p = 0; p < span; p++) begin
          m_rd[cyc]       = 1;
          m_a[cyc]        = base + p;
          m_b[cyc]        = base + p + span;
          m_k[cyc]        = p * (N / (2 * span));
          m_st[cyc]       = st;
          m_wr[cyc+PIPE]  = 1;
          m_wa[cyc+PIPE]  = base + p;
          m_wb[cyc+PIPE]  = base + p + span;
          m_ws[cyc+PIPE]  = SCALE[st];
          m_wst[cyc+PIPE] = st;
          cyc++;
        end
      end
    end
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("idle_outs@%0d", i), 32'(all_outs), 32'h0);
      @(posedge clk); #1;
    end
  endtask

  // Starts a transform at the next edge and checks every cycle through DC+1.
  task automatic run_transform(input bit spot, input int pulse1, input int pulse2,
                               input bit hold);
    int n_done;
    int n_wr;
    int ovl;
    int st;
    logic [15:0] cov [LOGN];
    logic [15:0] mask;
    n_done = 0; n_wr = 0; ovl = 0;
    for (int i = 0; i < LOGN; i++) cov[i] = '0;
    bus_if.start = 1'b1;
    @(posedge clk); #1;
    if (!hold) bus_if.start = 1'b0;
    for (int c = 1; c <= DC; c++) begin
      if (c == pulse1 || c == pulse2) bus_if.start = 1'b1;
      else if (!hold) bus_if.start = 1'b0;
      @(negedge clk);
      chk($sformatf("busy@%0d", c), 32'(bus_if.busy), 32'(1));
      chk($sformatf("done@%0d", c), 32'(bus_if.done), 32'(c == DC));
      chk($sformatf("rd_en@%0d", c), 32'(bus_if.rd_en), 32'(m_rd[c]));
      if (m_rd[c]) begin
        chk($sformatf("rd_a@%0d", c), 32'(bus_if.rd_addr_a), 32'(m_a[c]));
        chk($sformatf("rd_b@%0d", c), 32'(bus_if.rd_addr_b), 32'(m_b[c]));
        chk($sformatf("tw@%0d", c), 32'(bus_if.tw_idx), 32'(m_k[c]));
        chk($sformatf("stage@%0d", c), 32'(bus_if.stage), 32'(m_st[c]));
      end
      chk($sformatf("wr_en@%0d", c), 32'(bus_if.wr_en), 32'(m_wr[c]));
      if (m_wr[c]) begin
        chk($sformatf("wr_a@%0d", c), 32'(bus_if.wr_addr_a), 32'(m_wa[c]));
        chk($sformatf("wr_b@%0d", c), 32'(bus_if.wr_addr_b), 32'(m_wb[c]));
        chk($sformatf("wr_scale@%0d", c), 32'(bus_if.wr_scale), 32'(m_ws[c]));
      end
      if (spot) begin
        if (c == 1) begin
          chk("spot_s0j0_a", 32'(bus_if.rd_addr_a), 32'd0);
          chk("spot_s0j0_b", 32'(bus_if.rd_addr_b), 32'd1);
          chk("spot_s0j0_k", 32'(bus_if.tw_idx), 32'd0);
        end
        if (c == 2) begin
          chk("spot_s0j1_a", 32'(bus_if.rd_addr_a), 32'd2);
          chk("spot_s0j1_b", 32'(bus_if.rd_addr_b), 32'd3);
          chk("spot_s0j1_k", 32'(bus_if.tw_idx), 32'd0);
        end
        if (c == 13) begin
          chk("spot_s1j1_a", 32'(bus_if.rd_addr_a), 32'd1);
          chk("spot_s1j1_b", 32'(bus_if.rd_addr_b), 32'd3);
          chk("spot_s1j1_k", 32'(bus_if.tw_idx), 32'd4);
        end
        if (c == 41) begin
          chk("spot_s3j7_a", 32'(bus_if.rd_addr_a), 32'd7);
          chk("spot_s3j7_b", 32'(bus_if.rd_addr_b), 32'd15);
          chk("spot_s3j7_k", 32'(bus_if.tw_idx), 32'd7);
        end
        if (c == 45) chk("spot_done45", 32'(bus_if.done), 32'd1);
      end
      if (bus_if.done) n_done++;
      if (bus_if.wr_en) begin
        n_wr++;
        st   = m_wst[c];
        mask = (16'h1 << bus_if.wr_addr_a) | (16'h1 << bus_if.wr_addr_b);
        if ((cov[st] & mask) != 0) ovl++;
        cov[st] = cov[st] | mask;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("post_busy", 32'(bus_if.busy), 32'd0);
    chk("post_rd_en", 32'(bus_if.rd_en), 32'd0);
    chk("post_wr_en", 32'(bus_if.wr_en), 32'd0);
    chk("done_count", 32'(n_done), 32'd1);
    chk("wr_count", 32'(n_wr), 32'(LOGN * HALF));
    chk("wr_overlap", 32'(ovl), 32'd0);
    for (int i = 0; i < LOGN; i++)
      chk($sformatf("stage%0d_cover", i), 32'(cov[i]), 32'h0000ffff);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    build_model();
    bus_if.start = 1'b0;
    rst = 1'b1;
    #1;
    chk("reset_outs", 32'(all_outs), 32'h0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    idle_cycles(50);

    run_transform(1'b1, 10, 0, 1'b0);

    for (int r = 0; r < 3; r++) begin
      idle_cycles($urandom_range(0, 4));
      run_transform(1'b0, $urandom_range(2, DC - 1), $urandom_range(2, DC - 1), 1'b0);
    end

    run_transform(1'b0, 0, 0, 1'b1);
    run_transform(1'b1, 0, 0, 1'b0);

    // Reset in the middle of a transform.
    @(posedge clk); #1;
    bus_if.start = 1'b1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    for (int c = 1; c < 20; c++) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_busy", 32'(bus_if.busy), 32'd1);
    chk("pre_rst_wr_en", 32'(bus_if.wr_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_outs", 32'(all_outs), 32'h0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    idle_cycles(20);
    run_transform(1'b1, 0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
